// File: rtl/fp_pkg.sv
// Shared definitions for the FP conversion blocks: rounding modes, exponent
// biases, format select encoding and the converter state type.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int SP_BIAS = 127;
  localparam int DP_BIAS = 1023;

  localparam logic FMT_DOUBLE = 1'b1;
  localparam logic FMT_SINGLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_round_inc.sv
// Round-up decision for a narrowing FP conversion, given the kept lsb, the
// guard and sticky bits, the result sign and the rounding mode.
module fp_round_inc
  import fp_pkg::*;
(
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  input  logic [2:0] rm_i,
  output logic       round_up_o
);

  // Reserved encodings fall through to round-to-nearest-even.
  always_comb begin
    round_up_o = guard_i & (sticky_i | lsb_i);
    case (rm_i)
      RM_RTZ:  round_up_o = 1'b0;
      RM_RDN:  round_up_o = sign_i & (guard_i | sticky_i);
      RM_RUP:  round_up_o = ~sign_i & (guard_i | sticky_i);
      RM_RMM:  round_up_o = guard_i;
      default: round_up_o = guard_i & (sticky_i | lsb_i);
    endcase
  end

endmodule

// File: rtl/int_to_fp_convert.sv
// Multi-cycle 32-bit integer to single/double conversion: normalises one bit
// per cycle, rounds in a single cycle and holds the result until consumed.
module int_to_fp_convert
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_signed,
  input  logic                  in_fmt,
  input  logic [2:0]            in_rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_flag_nx
);

  state_e                  state_q;
  logic                    sign_q;
  logic [31:0]             mag_q;
  logic                    fmt_q;
  logic [2:0]              rm_q;
  logic [4:0]              exp_cnt_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    nx_q;

  logic                    in_neg;
  logic [31:0]             in_mag;
  logic [22:0]             sp_frac;
  logic                    sp_guard;
  logic                    sp_sticky;
  logic                    sp_round_up;
  logic [23:0]             sp_frac_sum;
  logic [7:0]              sp_exp;
  logic [10:0]             dp_exp;
  logic [63:0]             sp_result_d;
  logic [63:0]             dp_result_d;
  logic [63:0]             zero_result_d;
  logic                    nx_d;

  assign in_neg = in_signed & in_data[31];
  assign in_mag = in_neg ? (~in_data + 32'd1) : in_data;

  assign sp_frac   = mag_q[30:8];
  assign sp_guard  = mag_q[7];
  assign sp_sticky = |mag_q[6:0];

  fp_round_inc u_round_inc (
    .sign_i     (sign_q),
    .lsb_i      (mag_q[8]),
    .guard_i    (sp_guard),
    .sticky_i   (sp_sticky),
    .rm_i       (rm_q),
    .round_up_o (sp_round_up)
  );

  // A carry out of the fraction leaves it all zeros and bumps the exponent;
  // with at most 2^32 in magnitude this can never reach infinity.
  assign sp_frac_sum = {1'b0, sp_frac} + {23'd0, sp_round_up};
  assign sp_exp      = 8'(exp_cnt_q) + 8'(SP_BIAS) + {7'd0, sp_frac_sum[23]};
  assign dp_exp      = 11'(exp_cnt_q) + 11'(DP_BIAS);

  assign sp_result_d   = {32'hFFFF_FFFF, sign_q, sp_exp, sp_frac_sum[22:0]};
  assign dp_result_d   = {sign_q, dp_exp, mag_q[30:0], 21'd0};
  assign zero_result_d = (fmt_q == FMT_DOUBLE) ? 64'd0 : {32'hFFFF_FFFF, 32'd0};
  assign nx_d          = (fmt_q == FMT_DOUBLE) ? 1'b0 : (sp_guard | sp_sticky);

  // A zero operand is recognised in its first NORM cycle and goes straight to
  // DONE, so it completes one edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= 32'd0;
      fmt_q      <= 1'b0;
      rm_q       <= 3'd0;
      exp_cnt_q  <= 5'd0;
      out_data_q <= '0;
      nx_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q    <= in_neg;
            mag_q     <= in_mag;
            fmt_q     <= in_fmt;
            rm_q      <= in_rm;
            exp_cnt_q <= 5'd31;
            state_q   <= NORM;
          end
        end
        NORM: begin
          if (mag_q == 32'd0) begin
            out_data_q <= DATA_WIDTH'(zero_result_d);
            nx_q       <= 1'b0;
            state_q    <= DONE;
          end else if (mag_q[31]) begin
            state_q <= ROUND;
          end else begin
            mag_q     <= {mag_q[30:0], 1'b0};
            exp_cnt_q <= exp_cnt_q - 5'd1;
          end
        end
        ROUND: begin
          out_data_q <= DATA_WIDTH'((fmt_q == FMT_DOUBLE) ? dp_result_d : sp_result_d);
          nx_q       <= nx_d;
          state_q    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_data    = out_data_q;
  assign out_flag_nx = nx_q;

endmodule

// File: tb/tb_int_to_fp_convert.sv
// Directed-vector bench for int_to_fp_convert: hand-computed results, flags,
// latencies, back-pressure hold and a reset pulse during normalisation.
module tb_int_to_fp_convert;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        in_fmt;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_flag_nx;

  int checkCount = 0;
  int passCount  = 0;

  int_to_fp_convert #(.DATA_WIDTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .in_fmt      (in_fmt),
    .in_rm       (in_rm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flag_nx (out_flag_nx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Issue one request and wait (bounded) for out_valid; no handshake yet.
  task automatic applyStimulus(input logic [31:0] data, input logic sgn,
                               input logic fmt, input logic [2:0] rm,
                               output int lat);
    int timedOut;
    timedOut = 0;
    @(negedge clk);
    in_data   = data;
    in_signed = sgn;
    in_fmt    = fmt;
    in_rm     = rm;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
      if (lat > 100) begin
        timedOut = 1;
        break;
      end
    end
    checkOutput("timeout", 64'(timedOut), 64'd0);
  endtask

  task automatic finishHandshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput("readyAfterHs", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic runVector(input string tag, input logic [31:0] data,
                           input logic sgn, input logic fmt, input logic [2:0] rm,
                           input logic [63:0] expData, input logic expNx,
                           input int expLat);
    int lat;
    applyStimulus(data, sgn, fmt, rm, lat);
    checkOutput({tag, ".data"}, out_data, expData);
    checkOutput({tag, ".nx"}, {63'd0, out_flag_nx}, {63'd0, expNx});
    if (expLat > 0) checkOutput({tag, ".lat"}, 64'(lat), 64'(expLat));
    finishHandshake();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_signed = 1'b0;
    in_fmt    = 1'b0;
    in_rm     = 3'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checkOutput("rst.inReady", {63'd0, in_ready}, 64'd1);
    checkOutput("rst.outValid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst.outData", out_data, 64'd0);
    checkOutput("rst.nx", {63'd0, out_flag_nx}, 64'd0);

    runVector("one.dp", 32'h0000_0001, 1'b1, 1'b1, 3'b000, 64'h3FF0_0000_0000_0000, 1'b0, 33);
    runVector("m1.sp", 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b000, 64'hFFFF_FFFF_BF80_0000, 1'b0, 33);
    runVector("umax.sp", 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_4F80_0000, 1'b1, 2);
    runVector("min.dp", 32'h8000_0000, 1'b1, 1'b1, 3'b000, 64'hC1E0_0000_0000_0000, 1'b0, 2);
    runVector("u2p31.sp", 32'h8000_0000, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_4F00_0000, 1'b0, 2);
    runVector("tie.rne", 32'h0100_0001, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_4B80_0000, 1'b1, 9);
    runVector("tie.rup", 32'h0100_0001, 1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_4B80_0001, 1'b1, 9);
    runVector("tie.rtz", 32'h0100_0001, 1'b0, 1'b0, 3'b001, 64'hFFFF_FFFF_4B80_0000, 1'b1, 9);
    runVector("tie.rmm", 32'h0100_0001, 1'b0, 1'b0, 3'b100, 64'hFFFF_FFFF_4B80_0001, 1'b1, 9);
    runVector("neg.rdn", 32'hFEFF_FFFF, 1'b1, 1'b0, 3'b010, 64'hFFFF_FFFF_CB80_0001, 1'b1, 9);
    runVector("neg.rup", 32'hFEFF_FFFF, 1'b1, 1'b0, 3'b011, 64'hFFFF_FFFF_CB80_0000, 1'b1, 9);
    runVector("odd.rm7", 32'h0100_0003, 1'b0, 1'b0, 3'b111, 64'hFFFF_FFFF_4B80_0002, 1'b1, 9);
    runVector("zero.dp", 32'h0000_0000, 1'b1, 1'b1, 3'b000, 64'h0, 1'b0, 1);

    // Zero operand in single precision under back-pressure.
    applyStimulus(32'h0, 1'b1, 1'b0, 3'b000, lat);
    checkOutput("zero.sp.lat", 64'(lat), 64'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("zero.sp.hold.data", out_data, 64'hFFFF_FFFF_0000_0000);
      checkOutput("zero.sp.hold.nx", {63'd0, out_flag_nx}, 64'd0);
      checkOutput("zero.sp.hold.valid", {63'd0, out_valid}, 64'd1);
      checkOutput("zero.sp.hold.inReady", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    finishHandshake();

    // Reset pulse while the long normalisation of 1 is in progress.
    @(negedge clk);
    in_data   = 32'h0000_0001;
    in_signed = 1'b0;
    in_fmt    = 1'b1;
    in_rm     = 3'b000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst.outValid", {63'd0, out_valid}, 64'd0);
    checkOutput("midRst.inReady", {63'd0, in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checkOutput("postRst.inReady", {63'd0, in_ready}, 64'd1);
    checkOutput("postRst.outValid", {63'd0, out_valid}, 64'd0);
    checkOutput("postRst.outData", out_data, 64'd0);
    runVector("postRst.rup", 32'h0100_0001, 1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_4B80_0001, 1'b1, 9);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
